// File: rtl/psx_pkg.sv
// Shared PSX definitions: byte width, default ACK timing and the byte type.
package psx_pkg;
  localparam int PSX_BYTE_BITS        = 8;
  localparam int PSX_ACK_DELAY_US_DEF = 8;
  localparam int PSX_ACK_WIDTH_US_DEF = 3;

  typedef logic [PSX_BYTE_BITS-1:0] psx_byte_t;
endpackage

// File: rtl/psx_device_port_fifo_if.sv
// Synchronized PSX serial bus as seen by a device: host drives CLK/CMD, device drives DAT/ACK.
interface psx_device_port_fifo_if;
  logic psx_clk;
  logic psx_cmd;
  logic psx_dat_out;
  logic psx_dat_oe;
  logic psx_ack_out;

  modport master (
    output psx_clk, psx_cmd,
    input  psx_dat_out, psx_dat_oe, psx_ack_out
  );

  modport slave (
    input  psx_clk, psx_cmd,
    output psx_dat_out, psx_dat_oe, psx_ack_out
  );
endinterface

// File: rtl/psx_reply_fifo.sv
// Synchronous reply FIFO; pushes while full are dropped, push and pop may share a cycle.
module psx_reply_fifo
  import psx_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = PSX_BYTE_BITS,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             PPB_packet_reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == (AW+1)'(DEPTH));
  assign push_ok = push & ~full;
  assign pop_ok  = pop & (count != '0);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or posedge PPB_packet_reset) begin
    if (PPB_packet_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; occupancy alone says what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/psx_device_port_fifo.sv
// PSX device-side serial adapter with reply FIFO and cycle-exact ACK timing.
// Optional inter-edge watchdog enabled by defining PSX_DEVPORT_TIMEOUT_EN.
module psx_device_port_fifo
  import psx_pkg::*;
#(
  parameter int CLOCK_MHZ    = 25,
  parameter int ACK_DELAY_US = PSX_ACK_DELAY_US_DEF,
  parameter int ACK_WIDTH_US = PSX_ACK_WIDTH_US_DEF,
  parameter int REPLY_DEPTH  = 8,
  parameter int IDX_BITS     = 4,
`ifdef PSX_DEVPORT_TIMEOUT_EN
  parameter int TIMEOUT_US   = 100,
`endif
  parameter int AUTO_ACK     = 0
) (
  input  logic                         clk,
  input  logic                         PPB_packet_reset,
  psx_device_port_fifo_if.slave        psx,
  output psx_byte_t                    PPB_command,
  output logic                         PPB_command_strobe,
  output logic [IDX_BITS-1:0]          PPB_byte_index,
  input  psx_byte_t                    PPB_reply,
  input  logic                         PPB_reply_push,
  output logic                         PPB_reply_full,
  output logic [$clog2(REPLY_DEPTH):0] PPB_reply_count,
  input  logic                         PPB_ack_strobe,
  output logic                         PPB_error
);

  localparam int ACK_D  = CLOCK_MHZ * ACK_DELAY_US;
  localparam int ACK_DW = ACK_D + CLOCK_MHZ * ACK_WIDTH_US;
  localparam int ACK_CW = $clog2(ACK_DW + 1);
  localparam logic [ACK_CW-1:0]   ACK_D_C  = ACK_CW'(ACK_D);
  localparam logic [ACK_CW-1:0]   ACK_DW_C = ACK_CW'(ACK_DW);
  localparam logic [IDX_BITS-1:0] IDX_MAX  = '1;

  logic              clk_prev;
  logic              rise;
  logic              fall;
  logic [2:0]        bit_cnt;
  logic [6:0]        shift_in;
  logic              byte_done;
  logic              first_done;
  psx_byte_t         out_sr;
  logic              dat_oe;
  logic              fifo_pop;
  psx_byte_t         fifo_head;
  logic              wd_fire;
  logic [ACK_CW-1:0] ack_cnt;
  logic [ACK_CW-1:0] ack_cnt_n;
  logic              armed;
  logic              armed_n;
  logic              ack_out;
  logic              ack_n;

  assign rise      = psx.psx_clk & ~clk_prev;
  assign fall      = ~psx.psx_clk & clk_prev;
  assign byte_done = rise && (bit_cnt == 3'd7);
  assign fifo_pop  = fall && (bit_cnt == 3'd0) && (PPB_reply_count != '0);

  psx_reply_fifo #(
    .DEPTH (REPLY_DEPTH),
    .WIDTH (PSX_BYTE_BITS)
  ) u_reply_fifo (
    .clk              (clk),
    .PPB_packet_reset (PPB_packet_reset),
    .push             (PPB_reply_push),
    .din              (PPB_reply),
    .pop              (fifo_pop),
    .dout             (fifo_head),
    .full             (PPB_reply_full),
    .count            (PPB_reply_count)
  );

  // Command receive: CMD sampled on rising CLK, LSB first.
  always_ff @(posedge clk or posedge PPB_packet_reset) begin
    if (PPB_packet_reset) begin
      clk_prev           <= 1'b1;
      bit_cnt            <= '0;
      shift_in           <= '0;
      PPB_command        <= '0;
      PPB_command_strobe <= 1'b0;
      PPB_byte_index     <= '0;
      first_done         <= 1'b0;
    end else begin
      clk_prev           <= psx.psx_clk;
      PPB_command_strobe <= byte_done;
      if (wd_fire) begin
        bit_cnt <= '0;
      end else if (rise) begin
        shift_in <= {psx.psx_cmd, shift_in[6:1]};
        bit_cnt  <= bit_cnt + 3'd1;
      end
      if (byte_done) begin
        PPB_command <= {psx.psx_cmd, shift_in};
        first_done  <= 1'b1;
        if (first_done && (PPB_byte_index != IDX_MAX))
          PPB_byte_index <= PPB_byte_index + 1'b1;
      end
    end
  end

  // Reply transmit: byte chosen at the first falling edge, shifted out on later ones.
  always_ff @(posedge clk or posedge PPB_packet_reset) begin
    if (PPB_packet_reset) begin
      out_sr <= '0;
      dat_oe <= 1'b0;
    end else if (wd_fire) begin
      dat_oe <= 1'b0;
    end else if (fall) begin
      if (bit_cnt == 3'd0) begin
        if (PPB_reply_count != '0) out_sr <= fifo_head;
        dat_oe <= (PPB_reply_count != '0);
      end else begin
        out_sr <= {1'b0, out_sr[7:1]};
      end
    end
  end

  // ACK window; the output register is loaded from next-state values so the
  // pulse starts exactly ACK_D cycles after the strobe cycle.
  always_comb begin
    ack_cnt_n = ack_cnt;
    armed_n   = armed;
    if (byte_done) begin
      ack_cnt_n = '0;
      armed_n   = (AUTO_ACK != 0) && (PPB_reply_count != '0);
    end else begin
      if (ack_cnt != ACK_DW_C) ack_cnt_n = ack_cnt + 1'b1;
      if (PPB_ack_strobe && (ack_cnt < ACK_D_C)) armed_n = 1'b1;
    end
    ack_n = armed_n && (ack_cnt_n >= ACK_D_C) && (ack_cnt_n < ACK_DW_C);
  end

  always_ff @(posedge clk or posedge PPB_packet_reset) begin
    if (PPB_packet_reset) begin
      ack_cnt <= ACK_DW_C;
      armed   <= 1'b0;
      ack_out <= 1'b0;
    end else begin
      ack_cnt <= ack_cnt_n;
      armed   <= armed_n;
      ack_out <= ack_n;
    end
  end

`ifdef PSX_DEVPORT_TIMEOUT_EN
  localparam int TO_CYC = CLOCK_MHZ * TIMEOUT_US;
  localparam int WD_W   = $clog2(TO_CYC + 1);

  logic [WD_W-1:0] wd_cnt;
  logic            err;

  assign wd_fire   = (bit_cnt != 3'd0) && !(rise || fall) && (wd_cnt == WD_W'(TO_CYC - 1));
  assign PPB_error = err;

  // Watchdog runs only while a byte is partially received.
  always_ff @(posedge clk or posedge PPB_packet_reset) begin
    if (PPB_packet_reset) begin
      wd_cnt <= '0;
      err    <= 1'b0;
    end else if (rise || fall || (bit_cnt == 3'd0) || wd_fire) begin
      wd_cnt <= '0;
      if (wd_fire) err <= 1'b1;
    end else begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end
`else
  assign wd_fire   = 1'b0;
  assign PPB_error = 1'b0;
`endif

  assign psx.psx_dat_out = out_sr[0];
  assign psx.psx_dat_oe  = dat_oe;
  assign psx.psx_ack_out = ack_out;

endmodule

// File: doc/psx_device_port_fifo.md
# psx_device_port_fifo

Parametrised successor to the PSX device-side serial adapter. It converts the synchronized PSX serial bus (CLK/CMD in, DAT/ACK out) into PPB command strobes and byte indices. A reply FIFO lets protocol logic preload a whole packet's reply bytes ahead of time. ACK delay and width are cycle-exact rather than prescaled, with an optional auto-ACK mode. It sits between the pad/synchronizer front end, which generates PPB_packet_reset from SEL, and the per-device protocol FSM.

## Interface
- CLOCK_MHZ, 25, system clock frequency
- ACK_DELAY_US, 8, command strobe to ACK assertion delay
- ACK_WIDTH_US, 3, ACK pulse width
- REPLY_DEPTH, 8, reply FIFO depth (power of 2, ≥2)
- IDX_BITS, 4, byte index width
- AUTO_ACK, 0, 1 = arm ACK automatically when FIFO non-empty at command strobe
- TIMEOUT_US, 100, inter-edge timeout (used only with the macro)
- clk  in  1  system clock
- PPB_packet_reset  in  1  reset, asynchronous, active-high (SEL inactive or global reset); clock clk
- psx_clk  in  1  PSX CLK, already synchronized to clk
- psx_cmd  in  1  PSX CMD, already synchronized
- psx_dat_out  out  1  DAT bit to drive
- psx_dat_oe  out  1  DAT output enable (0 = tri-state, reads 1)
- psx_ack_out  out  1  1 = drive ACK low
- PPB_command  out  8  last received command byte
- PPB_command_strobe  out  1  one-cycle pulse, PPB_command/PPB_byte_index new
- PPB_byte_index  out  IDX_BITS  index of byte in PPB_command, first = 0, saturating
- PPB_reply  in  8  byte to enqueue
- PPB_reply_push  in  1  enqueue PPB_reply this cycle
- PPB_reply_full  out  1  FIFO full
- PPB_reply_count  out  $clog2(REPLY_DEPTH)+1  FIFO occupancy
- PPB_ack_strobe  in  1  arm ACK for the current byte
- PPB_error  out  1  sticky timeout flag

## Operation
- Reset: all outputs 0, FIFO empty, bit counter 0, index 0, ACK disarmed.
- Edges: rising = psx_clk & ~prev, falling = ~psx_clk & prev; prev is registered.
- Input: on each rising edge, shift psx_cmd into bit 7 of the input shift register (LSB first) and increment the 3-bit counter. On counter wrap, register the byte into PPB_command and pulse the strobe.
- Byte index: 0 before the first byte. It increments on each strobe after the first, so PPB_byte_index is valid with its byte. It saturates at 2^IDX_BITS−1.
- Output: on the falling edge with bit counter = 0:
  - FIFO non-empty: pop the head into the output shift register and set psx_dat_oe=1.
  - FIFO empty: set psx_dat_oe=0 for the whole byte.
  - Each later falling edge shifts right; psx_dat_out = reg[0].
- FIFO: push when full is dropped (count unchanged). Push and pop in the same cycle both take effect. There is no bypass: a push into an empty FIFO in the pop cycle is not sent this byte.
- ACK counter: cleared on the strobe cycle and incremented each cycle, saturating at D+W, where D=CLOCK_MHZ*ACK_DELAY_US and W=CLOCK_MHZ*ACK_WIDTH_US.
- ACK arming:
  - PPB_ack_strobe accepted while counter < D, including the strobe cycle itself; later ignored.
  - AUTO_ACK=1: also armed at the strobe if count > 0.
- psx_ack_out = armed & D ≤ counter < D+W.
- A new command strobe disarms, restarts the counter and ends any pulse in progress.

## Timing
- PPB_command_strobe: 1 cycle after the cycle detecting the 8th rising edge.
- psx_ack_out first high exactly D cycles after the strobe cycle, high for W cycles (registered).
- psx_dat_out/oe change 1 cycle after the falling-edge detect cycle.
- PPB_reply_full/count update the cycle after push/pop.
- Reset mid-byte: immediate async clear; the partial byte is discarded with no strobe.

## Configuration
- PSX_DEVPORT_TIMEOUT_EN defined:
  - A watchdog counts cycles since the last psx_clk edge while bit counter ≠ 0.
  - On reaching CLOCK_MHZ*TIMEOUT_US it sets PPB_error (sticky until reset), clears the bit counter, discards the partial byte without a strobe, and sets psx_dat_oe=0 until the next byte start.
- Undefined: no watchdog; PPB_error tied 0.

## Structure
- Shared package psx_pkg: PSX_BYTE_BITS=8, default ACK delay/width constants, byte typedef.
- Sub-module psx_reply_fifo (synchronous FIFO, depth/width parameters, full/count outputs, same-cycle push/pop).

## Test plan
- Preload 0x41, 0x5A; host clocks 0x01, 0x42 at a 100-cycle CLK period → PPB_command 0x01 (index 0) then 0x42 (index 1); DAT carries 0x41, 0x5A LSB-first with oe=1.
- PPB_ack_strobe 10 cycles after strobe → ACK high on cycles 200–274 after strobe. Strobe at cycle 250 → no ACK.
- FIFO empty at byte start, push 0x73 mid-byte → oe=0 for that byte; next byte sends 0x73.
- Push 9 bytes, REPLY_DEPTH=8 → full=1, count=8, ninth dropped; pushed data reads back in order.
- PPB_packet_reset after 5 bits → all outputs 0; next full byte 0xA5 received correctly at index 0.
- Macro defined, TIMEOUT_US=100: CLK stops after 3 bits → PPB_error=1 at cycle 2500, no strobe.
